serial_adder_n: RTL and testbench
=================================

SERIAL_ADDER_N -- requirements
Module: serial_adder_n

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request a new operation; sampled on rising clk.
REQ-005 SHALL have port sub  input  1  mode: 0 = add, 1 = subtract; sampled with start.
REQ-006 SHALL have port a  input  WIDTH  operand A; sampled with start.
REQ-007 SHALL have port b  input  WIDTH  operand B; sampled with start.
REQ-008 SHALL have port cin  input  1  carry-in for add, borrow-in for subtract; sampled with start.
REQ-009 SHALL have port busy  output  1  high while an operation is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking result valid.
REQ-011 SHALL have port sum  output  WIDTH  registered result.
REQ-012 SHALL have port cout  output  1  final carry out of the MSB.
REQ-013 SHALL have port ovf  output  1  two's-complement overflow flag.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and DONE.
REQ-015 SHALL, in IDLE or DONE with start=1, capture a, b XOR {WIDTH{sub}}, sub, and initial carry = cin XOR sub, clear bit counter, and enter RUN.
REQ-016 SHALL, in RUN, process one bit per cycle, LSB first.
- full-adder cell: s_i = a_i^b_i^c; c_next = a_i&b_i | a_i&c | b_i&c.
- s_i shifted into an internal result register.
REQ-017 SHALL stay in RUN for exactly WIDTH cycles (counter 0..WIDTH-1), then enter DONE.
REQ-018 SHALL, on the DONE-entry edge, load sum, cout and ovf together.
- sum = internal result.
- cout = final carry.
- ovf = carry into MSB XOR carry out of MSB.
REQ-019 SHALL hold sum/cout/ovf at their previous values during RUN and until the next completion.
REQ-020 SHALL assert done only in DONE, for exactly one cycle; DONE returns to IDLE unless start=1.
REQ-021 SHALL assert busy exactly while in RUN.
REQ-022 SHALL give a latency of WIDTH+1 edges: start sampled at edge k gives done=1 in the cycle following edge k+WIDTH.
REQ-023 SHALL ignore start while busy=1; operands and mode remain those captured at start.
REQ-024 SHALL accept start during the DONE cycle (back-to-back) with no idle cycle; done still pulses for the completed operation.
REQ-025 SHALL produce sum = (a - b - cin) mod 2^WIDTH in subtract mode, with cout=1 meaning no borrow.
REQ-026 SHALL produce sum = (a + b + cin) mod 2^WIDTH in add mode; wrap-around is reported only via cout/ovf.

Reset
REQ-027 SHALL, on rst_n=0 at any time including mid-RUN, immediately force: state IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, counter and internal registers 0.
REQ-028 SHALL NOT complete or pulse done for an operation aborted by reset; the first start after rst_n rises begins a fresh operation.

Verification (WIDTH=8)
REQ-029 SHALL cover reset: rst_n low -> busy=0, done=0, sum=0x00, cout=0, ovf=0 asynchronously.
REQ-030 SHALL cover add a=0x5A, b=0x3C, cin=0 -> done 9 edges after start; sum=0x96, cout=0, ovf=1.
REQ-031 SHALL cover add a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; sum holds old value during RUN.
REQ-032 SHALL cover subtract.
- a=0x10, b=0x20, cin=0 -> sum=0xF0, cout=0, ovf=0.
- a=0x80, b=0x01, cin=0 -> sum=0x7F, cout=1, ovf=1.
REQ-033 SHALL cover start pulsed mid-RUN -> ignored, result unchanged; start held in DONE cycle -> second operation accepted, busy high next cycle, two done pulses WIDTH+1 cycles apart.
REQ-034 SHALL cover reset mid-operation: rst_n low after bit 3 -> busy=0 at once, no done pulse, sum=0x00; new start after release completes correctly.

Source files
------------

// File: rtl/serial_adder_n.sv
// Bit-serial adder/subtractor: one full-adder cell processes one operand bit
// per clock, LSB first, and the result is published when the operation completes.
module serial_adder_n #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             w_accept;
  logic             w_last;
  logic             w_s;
  logic             w_c;

  assign w_accept = (r_state != RUN) && start;
  assign w_last   = (r_state == RUN) && (r_cnt == LAST);
  assign w_s      = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_c      = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Subtraction is a + ~b + ~cin: b is inverted and the carry seeded at capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b ^ {WIDTH{sub}};
      r_carry <= cin ^ sub;
      r_res   <= '0;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_carry <= w_c;
      r_res   <= {w_s, r_res[WIDTH-1:1]};
      r_cnt   <= r_cnt + 1'b1;
      // On the MSB cycle r_carry is the carry into the MSB.
      if (w_last) begin
        r_sum  <= {w_s, r_res[WIDTH-1:1]};
        r_cout <= w_c;
        r_ovf  <= r_carry ^ w_c;
      end
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder_n.sv
// Directed self-checking bench for serial_adder_n at WIDTH=8: a vector table
// for add/subtract results plus hand sequences for timing, overlap and reset.
module tb_serial_adder_n;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] heldSum;

  typedef struct {
    string            name;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] expSum;
    logic             expCout;
    logic             expOvf;
  } vec_t;

  vec_t vecs[8];

  serial_adder_n #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .cin(cin), .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [WIDTH-1:0] va,
                               input logic [WIDTH-1:0] vb, input logic c);
    sub = s;
    a   = va;
    b   = vb;
    cin = c;
  endtask

  // Called #1 after the edge that sampled start; walks to the completion cycle.
  task automatic waitResult(input string name, input logic [WIDTH-1:0] expSum,
                            input logic expCout, input logic expOvf);
    checkOutput({name, " busy after start"}, busy, 1);
    for (int i = 1; i < WIDTH; i++) begin
      @(posedge clk); #1;
      checkOutput({name, " done early"}, done, 0);
      checkOutput({name, " sum held in RUN"}, sum, heldSum);
    end
    @(posedge clk); #1;
    checkOutput({name, " done pulse"}, done, 1);
    checkOutput({name, " busy in DONE"}, busy, 0);
    checkOutput({name, " sum"}, sum, expSum);
    checkOutput({name, " cout"}, cout, expCout);
    checkOutput({name, " ovf"}, ovf, expOvf);
    heldSum = expSum;
  endtask

  task automatic launch(input logic s, input logic [WIDTH-1:0] va,
                        input logic [WIDTH-1:0] vb, input logic c);
    @(negedge clk);
    applyStimulus(s, va, vb, c);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic runVector(input vec_t v);
    launch(v.sub, v.a, v.b, v.cin);
    waitResult(v.name, v.expSum, v.expCout, v.expOvf);
    @(posedge clk); #1;
    checkOutput({v.name, " done one cycle"}, done, 0);
    checkOutput({v.name, " sum kept in IDLE"}, sum, v.expSum);
  endtask

  initial begin
    vecs[0] = '{"add 5A+3C",     1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
    vecs[1] = '{"add FF+01",     1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{"sub 10-20",     1'b1, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b0, 1'b0};
    vecs[3] = '{"sub 80-01",     1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
    vecs[4] = '{"add 7F+01",     1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[5] = '{"add FF+FF+1",   1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{"sub 00-00-1",   1'b1, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[7] = '{"sub 7F-FF",     1'b1, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b0, 1'b1};

    start = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0);
    heldSum = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset sum", sum, 0);
    checkOutput("reset cout", cout, 0);
    checkOutput("reset ovf", ovf, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    foreach (vecs[i]) runVector(vecs[i]);

    // Start pulsed mid-RUN with different operands must not disturb the result.
    launch(1'b0, 8'h5A, 8'h3C, 1'b0);
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
    end
    applyStimulus(1'b1, 8'h00, 8'hFF, 1'b1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("mid-RUN start busy", busy, 1);
    for (int i = 5; i < WIDTH; i++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    checkOutput("mid-RUN start done", done, 1);
    checkOutput("mid-RUN start sum", sum, 8'h96);
    checkOutput("mid-RUN start ovf", ovf, 1);
    heldSum = 8'h96;
    @(posedge clk); #1;

    // Back-to-back: start held through the DONE cycle launches a second op.
    launch(1'b0, 8'hFF, 8'h01, 1'b0);
    waitResult("b2b first", 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h10, 8'h20, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("b2b done dropped", done, 0);
    waitResult("b2b second", 8'hF0, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Reset after bit 3 aborts the operation with no completion.
    launch(1'b0, 8'h5A, 8'h3C, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy", busy, 0);
    checkOutput("abort done", done, 0);
    checkOutput("abort sum", sum, 0);
    checkOutput("abort cout", cout, 0);
    @(negedge clk) rst_n = 1'b1;
    begin
      logic sawDone;
      sawDone = 1'b0;
      repeat (WIDTH + 3) begin
        @(posedge clk); #1;
        if (done || busy) sawDone = 1'b1;
      end
      checkOutput("abort no done/busy", sawDone, 0);
    end
    heldSum = '0;
    runVector(vecs[3]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
